// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: sync, 11-bit frame check, E0/F0 folding into tagged events, show-ahead event FIFO.
// Event visible 2 clk after the stop-bit fall pulse; a full FIFO drops new events (sticky overflow) unless popped that cycle.
module ps2_kbd_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic                          valid,
    output logic [7:0]                    code,
    output logic                          is_break,
    output logic                          is_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [7:0]                    press_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // Sync flops reset to the idle-high line level so reset release never fakes a fall.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   fall, data_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          byte_stb_q, byte_stb_d;
    logic [7:0]    byte_q, byte_d;
    logic [10:0]   frame_full;
    logic          chk_ok, timeout, bad;

    assign frame_full = {data_s, frame_q};
    assign chk_ok     = ~frame_full[0] & frame_full[10] & (^frame_full[9:1]);
    assign timeout    = (bitcnt_q != 4'd0) && (idle_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        frame_d    = frame_q;
        bitcnt_d   = bitcnt_q;
        idle_d     = idle_q;
        byte_stb_d = 1'b0;
        byte_d     = byte_q;
        bad        = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d   = 4'd0;
                byte_stb_d = chk_ok;
                byte_d     = frame_full[8:1];
                bad        = ~chk_ok;
            end else begin
                frame_d[bitcnt_q] = data_s;
                bitcnt_d          = bitcnt_q + 4'd1;
            end
        end else if (timeout) begin
            bitcnt_d = 4'd0;
            idle_d   = '0;
            bad      = 1'b1;
        end else if (bitcnt_q != 4'd0) begin
            idle_d = idle_q + 1'b1;
        end
    end

    logic ext_q, ext_d, brk_q, brk_d;
    logic push;
    evt_t evt_in;

    assign push   = byte_stb_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    assign evt_in = '{ext: ext_q, brk: brk_q, code: byte_q};

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        if (byte_stb_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    evt_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          full, pop, wr;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic [7:0]    press_q, press_d;
    evt_t          head;

    assign full = (count_q == LW'(FIFO_DEPTH));
    assign pop  = rd_en && (count_q != '0);
    assign wr   = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error wins over a simultaneous clear.
        ovf_d   = (ovf_q & ~err_clr) | (push & full & ~pop);
        ferr_d  = (ferr_q & ~err_clr) | bad;
        press_d = (push && brk_q) ? press_q + 8'd1 : press_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q    <= '0;
            bitcnt_q   <= '0;
            idle_q     <= '0;
            byte_stb_q <= 1'b0;
            byte_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            press_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            frame_q    <= frame_d;
            bitcnt_q   <= bitcnt_d;
            idle_q     <= idle_d;
            byte_stb_q <= byte_stb_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            press_q    <= press_d;
            if (wr) begin
                mem_q[wr_ptr_q] <= evt_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign valid       = (count_q != '0);
    assign code        = valid ? head.code : 8'h00;
    assign is_break    = valid & head.brk;
    assign is_ext      = valid & head.ext;
    assign fifo_level  = count_q;
    assign overflow    = ovf_q;
    assign frame_err   = ferr_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: table of decoded key events plus hand-written
// sequences for latency, errors, timeout, overflow, reset and counter wrap.
module tb_ps2_kbd_fifo;
    localparam int DEPTH = 4;
    localparam int SYNC  = 3;
    localparam int TMO   = 64;
    localparam int HALF  = 3;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, rd_en, err_clr;
    logic       valid, is_break, is_ext, overflow, frame_err;
    logic [7:0] code, press_count;
    logic [$clog2(DEPTH):0] fifo_level;

    ps2_kbd_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .err_clr(err_clr), .valid(valid), .code(code),
        .is_break(is_break), .is_ext(is_ext), .fifo_level(fifo_level),
        .overflow(overflow), .frame_err(frame_err), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] code;
        logic       e0;
        logic       f0;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
        logic [7:0] exp_press;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 1: check valid latency after the stop-bit fall; mode 2: pop in the FIFO write cycle.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits, input int mode);
        logic [10:0] f;
        logic        par;
        par = (~^d) ^ bad_par;
        f   = {1'b1, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                tick(SYNC + 1);
                chk("lat_before", {31'd0, valid}, 32'd0);
                tick(1);
                chk("lat_valid", {31'd0, valid}, 32'd1);
            end else if (i == 10 && mode == 2) begin
                tick(SYNC + 1);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(8);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{code: 8'h1C, e0: 1'b0, f0: 1'b0, exp_code: 8'h1C, exp_brk: 1'b0, exp_ext: 1'b0, exp_press: 8'd0};
        vecs[1] = '{code: 8'h75, e0: 1'b1, f0: 1'b1, exp_code: 8'h75, exp_brk: 1'b1, exp_ext: 1'b1, exp_press: 8'd1};
        vecs[2] = '{code: 8'h1C, e0: 1'b0, f0: 1'b1, exp_code: 8'h1C, exp_brk: 1'b1, exp_ext: 1'b0, exp_press: 8'd2};
        vecs[3] = '{code: 8'h6B, e0: 1'b1, f0: 1'b0, exp_code: 8'h6B, exp_brk: 1'b0, exp_ext: 1'b1, exp_press: 8'd2};
        vecs[4] = '{code: 8'h5A, e0: 1'b0, f0: 1'b0, exp_code: 8'h5A, exp_brk: 1'b0, exp_ext: 1'b0, exp_press: 8'd2};

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_code", {24'd0, code}, 32'd0);
        chk("rst_brk", {31'd0, is_break}, 32'd0);
        chk("rst_ext", {31'd0, is_ext}, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_press", {24'd0, press_count}, 32'd0);
        rst = 1'b1;
        tick(3);

        // Latency on the first frame, then the decode table.
        send_frame(8'h1C, 1'b0, 11, 1);
        chk("first_code", {24'd0, code}, 32'h1C);
        chk("first_level", 32'(fifo_level), 32'd1);
        pop1();
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].e0) send_frame(8'hE0, 1'b0, 11, 0);
            if (vecs[v].f0) send_frame(8'hF0, 1'b0, 11, 0);
            send_frame(vecs[v].code, 1'b0, 11, 0);
            chk("tbl_valid", {31'd0, valid}, 32'd1);
            chk("tbl_code", {24'd0, code}, {24'd0, vecs[v].exp_code});
            chk("tbl_brk", {31'd0, is_break}, {31'd0, vecs[v].exp_brk});
            chk("tbl_ext", {31'd0, is_ext}, {31'd0, vecs[v].exp_ext});
            chk("tbl_level", 32'(fifo_level), 32'd1);
            chk("tbl_press", {24'd0, press_count}, {24'd0, vecs[v].exp_press});
            pop1();
            chk("tbl_empty", {31'd0, valid}, 32'd0);
            chk("tbl_code0", {24'd0, code}, 32'd0);
        end

        // Parity error, recovery, sticky clear.
        send_frame(8'h1C, 1'b1, 11, 0);
        chk("par_ferr", {31'd0, frame_err}, 32'd1);
        chk("par_noevt", {31'd0, valid}, 32'd0);
        send_frame(8'h1B, 1'b0, 11, 0);
        chk("par_next_code", {24'd0, code}, 32'h1B);
        chk("par_sticky", {31'd0, frame_err}, 32'd1);
        pop1();
        pulse_clr();
        chk("par_clr", {31'd0, frame_err}, 32'd0);

        // Partial frame abandoned by timeout.
        send_frame(8'h23, 1'b0, 5, 0);
        chk("tmo_before", {31'd0, frame_err}, 32'd0);
        tick(TMO + 2);
        chk("tmo_ferr", {31'd0, frame_err}, 32'd1);
        chk("tmo_noevt", {31'd0, valid}, 32'd0);
        send_frame(8'h23, 1'b0, 11, 0);
        chk("tmo_next_code", {24'd0, code}, 32'h23);
        chk("tmo_next_ext", {31'd0, is_ext}, 32'd0);
        pop1();
        pulse_clr();

        // Overflow: DEPTH+1 makes, then a pop coinciding with a write on the full FIFO.
        send_frame(8'h15, 1'b0, 11, 0);
        send_frame(8'h1D, 1'b0, 11, 0);
        send_frame(8'h24, 1'b0, 11, 0);
        send_frame(8'h2D, 1'b0, 11, 0);
        send_frame(8'h2C, 1'b0, 11, 0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_head", {24'd0, code}, 32'h15);
        pulse_clr();
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        send_frame(8'h35, 1'b0, 11, 2);
        chk("popwr_level", 32'(fifo_level), 32'd4);
        chk("popwr_ovf", {31'd0, overflow}, 32'd0);
        chk("drain0", {24'd0, code}, 32'h1D);
        pop1();
        chk("drain1", {24'd0, code}, 32'h24);
        pop1();
        chk("drain2", {24'd0, code}, 32'h2D);
        pop1();
        chk("drain3", {24'd0, code}, 32'h35);
        pop1();
        chk("drain_empty", {31'd0, valid}, 32'd0);

        // Reset in the middle of a frame with state pending.
        send_frame(8'h44, 1'b1, 11, 0);
        send_frame(8'h4B, 1'b0, 11, 0);
        send_frame(8'h4D, 1'b0, 5, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_code", {24'd0, code}, 32'd0);
        chk("mrst_level", 32'(fifo_level), 32'd0);
        chk("mrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mrst_press", {24'd0, press_count}, 32'd0);
        tick(3);
        rst = 1'b1;
        tick(3);
        send_frame(8'h4D, 1'b0, 11, 0);
        chk("mrst_next_code", {24'd0, code}, 32'h4D);
        chk("mrst_next_level", 32'(fifo_level), 32'd1);
        chk("mrst_next_ferr", {31'd0, frame_err}, 32'd0);
        pop1();

        // 256 releases wrap the counter; FIFO fills and overflows along the way.
        for (int i = 0; i < 256; i++) begin
            send_frame(8'hF0, 1'b0, 11, 0);
            send_frame(8'h1C, 1'b0, 11, 0);
            if (i == 254) chk("wrap_255", {24'd0, press_count}, 32'd255);
        end
        chk("wrap_0", {24'd0, press_count}, 32'd0);
        chk("wrap_level", 32'(fifo_level), 32'd4);
        chk("wrap_brk", {31'd0, is_break}, 32'd1);
        rd_en = 1'b1;
        tick(10);
        chk("rd_empty_level", 32'(fifo_level), 32'd0);
        chk("rd_empty_valid", {31'd0, valid}, 32'd0);
        chk("rd_empty_code", {24'd0, code}, 32'd0);
        rd_en = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
